// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_ctrl byte-stream controller.
`timescale 1ns/1ps
package matmul_pkg;

    localparam int DW_DEF          = 8;
    localparam int RW_DEF          = 16;
    localparam int N_OPERAND_BYTES = 8;
    localparam int N_RESULT_BYTES  = 8;

    localparam int IDX_A0 = 0;
    localparam int IDX_A1 = 1;
    localparam int IDX_A2 = 2;
    localparam int IDX_A3 = 3;
    localparam int IDX_B0 = 4;
    localparam int IDX_B1 = 5;
    localparam int IDX_B2 = 6;
    localparam int IDX_B3 = 7;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND
    } state_t;

endpackage

// File: rtl/matmul_tx_ser.sv
// Parallel-load byte serializer: emits N_BYTES bytes LSB first with valid/ready and last.
`timescale 1ns/1ps
module matmul_tx_ser
    import matmul_pkg::*;
#(
    parameter int N_BYTES = N_RESULT_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [8*N_BYTES-1:0]   load_data,
    output logic                   valid,
    input  logic                   ready,
    output logic [7:0]             data,
    output logic                   last
);

    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

    logic [8*N_BYTES-1:0] sr;
    logic [CW-1:0]        idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            sr    <= load_data;
            idx   <= '0;
            valid <= 1'b1;
        end else if (valid && ready) begin
            // shifting past the final byte leaves data at zero once idle
            sr <= sr >> 8;
            if (idx == LAST_IDX) begin
                idx   <= '0;
                valid <= 1'b0;
            end else begin
                idx <= idx + CW'(1);
            end
        end
    end

    assign data = sr[7:0];
    assign last = valid && (idx == LAST_IDX);

endmodule

// File: rtl/matmul_ctrl.sv
// Byte-stream initiator for the 2x2 matrix_mul engine: load operands, start, wait, stream results.
// Build option MATMUL_CTRL_CHECK_EN adds a reference-product check driving mismatch_err.
//
// state      | meaning
// LOAD       | accept 8 operand bytes (A0..A3, B0..B3)
// START      | one-cycle start pulse, arm timeout
// WAIT       | wait for rising edge of done or timeout
// CAPTURE    | load C0..C3 into the serializer
// SEND       | stream 8 result bytes, back to LOAD after the last
`timescale 1ns/1ps
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int RW          = RW_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic [DW-1:0] A0,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] A2,
    output logic [DW-1:0] A3,
    output logic [DW-1:0] B0,
    output logic [DW-1:0] B1,
    output logic [DW-1:0] B2,
    output logic [DW-1:0] B3,
    output logic          start,
    input  logic          done,
    input  logic [RW-1:0] C0,
    input  logic [RW-1:0] C1,
    input  logic [RW-1:0] C2,
    input  logic [RW-1:0] C3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          busy,
    output logic          timeout_err,
    output logic          mismatch_err
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t         state, state_nxt;
    logic [2:0]     cnt;
    logic [DW-1:0]  opnd [N_OPERAND_BYTES];
    logic [TW-1:0]  tmr;
    logic           done_q;
    logic           done_edge;
    logic           in_hs;
    logic           send_end;

    assign in_ready  = (state == ST_LOAD) && !rst;
    assign in_hs     = in_valid && in_ready;
    assign done_edge = done && !done_q;
    assign busy      = (state != ST_LOAD);
    assign send_end  = out_valid && out_ready && out_last;

    assign A0 = opnd[IDX_A0];
    assign A1 = opnd[IDX_A1];
    assign A2 = opnd[IDX_A2];
    assign A3 = opnd[IDX_A3];
    assign B0 = opnd[IDX_B0];
    assign B1 = opnd[IDX_B1];
    assign B2 = opnd[IDX_B2];
    assign B3 = opnd[IDX_B3];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_LOAD:    if (in_hs && cnt == 3'd7) state_nxt = ST_START;
            ST_START: begin
                start     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge)       state_nxt = ST_CAPTURE;
                else if (tmr == '0)  state_nxt = ST_LOAD;
            end
            ST_CAPTURE: state_nxt = ST_SEND;
            ST_SEND:    if (send_end) state_nxt = ST_LOAD;
            default:    state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            tmr         <= '0;
            done_q      <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N_OPERAND_BYTES; i++) opnd[i] <= '0;
        end else begin
            done_q <= done;
            if (in_hs) begin
                opnd[cnt]   <= DW'(in_data);
                cnt         <= cnt + 3'd1;
                timeout_err <= 1'b0;
            end
            // down-counter: WAIT lasts at most TIMEOUT_CYC cycles
            if (state == ST_START)
                tmr <= TW'(TIMEOUT_CYC - 1);
            else if (state == ST_WAIT && tmr != '0)
                tmr <= tmr - TW'(1);
            if (state == ST_WAIT && !done_edge && tmr == '0)
                timeout_err <= 1'b1;
        end
    end

    matmul_tx_ser #(
        .N_BYTES (N_RESULT_BYTES)
    ) u_tx_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (state == ST_CAPTURE),
        .load_data ({C3, C2, C1, C0}),
        .valid     (out_valid),
        .ready     (out_ready),
        .data      (out_data),
        .last      (out_last)
    );

`ifdef MATMUL_CTRL_CHECK_EN
    logic [RW-1:0] ref_c [4];
    logic          chk_fail;

    always_comb begin
        ref_c[0] = RW'(A0) * RW'(B0) + RW'(A1) * RW'(B2);
        ref_c[1] = RW'(A0) * RW'(B1) + RW'(A1) * RW'(B3);
        ref_c[2] = RW'(A2) * RW'(B0) + RW'(A3) * RW'(B2);
        ref_c[3] = RW'(A2) * RW'(B1) + RW'(A3) * RW'(B3);
    end

    // compare registered first, flag raised one cycle later during SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_fail     <= 1'b0;
            mismatch_err <= 1'b0;
        end else begin
            chk_fail <= (state == ST_CAPTURE) &&
                        ((C0 != ref_c[0]) || (C1 != ref_c[1]) ||
                         (C2 != ref_c[2]) || (C3 != ref_c[3]));
            if (in_hs)         mismatch_err <= 1'b0;
            else if (chk_fail) mismatch_err <= 1'b1;
        end
    end
`else
    assign mismatch_err = 1'b0;
`endif

endmodule
